// File: rtl/pipe_buf_pkg.sv
// Shared widths and sizing helpers for the inter-stage pipeline buffers.
// Field widths match the decode->ALU, ALU->mem and mem->WB bundles.
package pipe_buf_pkg;

    localparam int WbSize  = 2;
    localparam int MemSize = 8;
    localparam int ExSize  = 11;

    localparam int DecAluCtrlWidth = WbSize + MemSize + ExSize;
    localparam int DecAluDataWidth = 91;

    localparam int AluMemCtrlWidth = WbSize + MemSize;
    localparam int AluMemDataWidth = 32 + 32 + 5;

    localparam int MemWbCtrlWidth = WbSize;
    localparam int MemWbDataWidth = 32 + 32 + 5;

    // Bits needed to hold an occupancy of 0..depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Bits needed to address depth entries (at least one).
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pipe_buf_mem.sv
// Entry storage for the elastic buffer: registered array with one
// synchronous write port, one asynchronous read port and a sync clear.
module pipe_buf_mem #(
    parameter int Depth = 2,
    parameter int Width = 112,
    parameter int PtrW  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [PtrW-1:0]  waddr,
    input  logic [Width-1:0] wdata,
    input  logic [PtrW-1:0]  raddr,
    output logic [Width-1:0] rdata
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];

    // Next array contents: one entry replaced on a write.
    always_comb begin
        mem_d = mem_q;
        if (we && (int'(waddr) < Depth)) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array update with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    // Asynchronous read of the addressed entry.
    always_comb begin
        rdata = '0;
        if (int'(raddr) < Depth) begin
            rdata = mem_q[raddr];
        end
    end

endmodule

// File: rtl/pipe_elastic_buf.sv
// Elastic valid/ready buffer between pipeline stages. Control bundle is
// zeroed on bubbles; data bundle holds the last popped value when empty.
module pipe_elastic_buf
    import pipe_buf_pkg::*;
#(
    parameter int CtrlWidth = DecAluCtrlWidth,
    parameter int DataWidth = DecAluDataWidth,
    parameter int Depth     = 2,
    parameter bit NegEdge   = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_flush,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic [CtrlWidth-1:0]         i_ctrl,
    input  logic [DataWidth-1:0]         i_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [CtrlWidth-1:0]         o_ctrl,
    output logic [DataWidth-1:0]         o_data,
    output logic [$clog2(Depth+1)-1:0]   o_count
);

    localparam int CntW  = cnt_width(Depth);
    localparam int PtrW  = ptr_width(Depth);
    localparam int WordW = CtrlWidth + DataWidth;

    logic                 clk_act;
    logic [CntW-1:0]      count_q, count_d;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] last_q, last_d;
    logic [WordW-1:0]     rd_word;
    logic [CtrlWidth-1:0] head_ctrl;
    logic [DataWidth-1:0] head_data;
    logic                 push;
    logic                 pop;
    logic                 mem_we;

    // Explicit wrap so non power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign clk_act = NegEdge ? ~clk : clk;

    assign o_ready = (count_q != CntW'(Depth));
    assign o_valid = (count_q != '0);
    assign o_count = count_q;

    assign push   = i_valid & o_ready;
    assign pop    = o_valid & i_ready;
    assign mem_we = push & ~i_flush;

    assign head_ctrl = rd_word[WordW-1:DataWidth];
    assign head_data = rd_word[DataWidth-1:0];

    pipe_buf_mem #(
        .Depth (Depth),
        .Width (WordW),
        .PtrW  (PtrW)
    ) u_mem (
        .clk   (clk_act),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata ({i_ctrl, i_data}),
        .raddr (rd_ptr_q),
        .rdata (rd_word)
    );

    // Pointer, occupancy and held-data next state; flush beats push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
                last_d   = head_data;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers on the selected edge; reset overrides everything.
    always_ff @(posedge clk_act) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    // Outputs are register-only: bubble control when empty.
    always_comb begin
        o_ctrl = '0;
        o_data = last_q;
        if (o_valid) begin
            o_ctrl = head_ctrl;
            o_data = head_data;
        end
    end

endmodule
